// File: rtl/trivium_pkg.sv
`default_nettype none
// ============================================================================
// Package     : trivium_pkg
// Description : Shared Trivium definitions: widths, tap indices, receive FSM
//               state encoding and the single-step keystream function.
//               Used by both the encryptor and the receive-side decryptor.
// Revision    : 1.0 - initial release
// ============================================================================
package trivium_pkg;

  localparam int KEY_W_DEF = 80;
  localparam int IV_W_DEF  = 80;
  localparam int STATE_W   = 288;

  // Bit index of s94 (first IV bit) inside st[287:0]; s_i lives at st[i-1].
  localparam int IV_BASE   = 93;

  // Lowest bit of the second (s94..s177) and third (s178..s288) registers.
  localparam int REG_B_LO  = 93;
  localparam int REG_C_LO  = 177;

  // Tap indices, 0-based (s66 -> 65, etc.).
  localparam int TAP_A_OUT  = 65;   // s66
  localparam int TAP_A_FB   = 92;   // s93
  localparam int TAP_A_AND0 = 90;   // s91
  localparam int TAP_A_AND1 = 91;   // s92
  localparam int TAP_A_X    = 170;  // s171
  localparam int TAP_B_OUT  = 161;  // s162
  localparam int TAP_B_FB   = 176;  // s177
  localparam int TAP_B_AND0 = 174;  // s175
  localparam int TAP_B_AND1 = 175;  // s176
  localparam int TAP_B_X    = 263;  // s264
  localparam int TAP_C_OUT  = 242;  // s243
  localparam int TAP_C_FB   = 287;  // s288
  localparam int TAP_C_AND0 = 285;  // s286
  localparam int TAP_C_AND1 = 286;  // s287
  localparam int TAP_C_X    = 68;   // s69

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    INIT = 2'd2,
    RUN  = 2'd3
  } rx_state_e;

  // One Trivium round: returns {z, st_next}.
  function automatic logic [STATE_W:0] trivium_step(input logic [STATE_W-1:0] st);
    logic               t1;
    logic               t2;
    logic               t3;
    logic               zb;
    logic [STATE_W-1:0] nx;
    t1 = st[TAP_A_OUT] ^ st[TAP_A_FB];
    t2 = st[TAP_B_OUT] ^ st[TAP_B_FB];
    t3 = st[TAP_C_OUT] ^ st[TAP_C_FB];
    zb = t1 ^ t2 ^ t3;
    t1 = t1 ^ (st[TAP_A_AND0] & st[TAP_A_AND1]) ^ st[TAP_A_X];
    t2 = t2 ^ (st[TAP_B_AND0] & st[TAP_B_AND1]) ^ st[TAP_B_X];
    t3 = t3 ^ (st[TAP_C_AND0] & st[TAP_C_AND1]) ^ st[TAP_C_X];
    nx = {st[STATE_W-2:REG_C_LO], t2,
          st[REG_C_LO-2:REG_B_LO], t1,
          st[REG_B_LO-2:0], t3};
    return {zb, nx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_core.sv
`default_nettype none
// ============================================================================
// Module      : trivium_core
// Description : 288-bit Trivium state register with parallel load, single
//               step enable and combinational keystream bit z.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_core
  import trivium_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STATE_W-1:0] load_val,
  input  logic               step,
  output logic               z
);

  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] st_next;

  assign {z, st_next} = trivium_step(st);

  // State register: load has priority over step; holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= '0;
    end else if (load) begin
      st <= load_val;
    end else if (step) begin
      st <= st_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trivium_rx_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : trivium_rx_decrypt
// Description : Receive-side Trivium stream decryptor. Serial key+IV load,
//               warm-up, then ct XOR keystream into a one-entry pt register.
//               Optional keystream usage limit: define TRIVIUM_RX_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module trivium_rx_decrypt
  import trivium_pkg::*;
#(
  parameter int              KEY_W       = KEY_W_DEF,
  parameter int              IV_W        = IV_W_DEF,
  parameter int              INIT_ROUNDS = 1152,
  parameter longint unsigned MAX_BITS    = 64'd4294967296
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_bit,
  input  logic cfg_vld,
  input  logic ct_bit,
  input  logic ct_vld,
  output logic ct_rdy,
  output logic pt_bit,
  output logic pt_vld,
  input  logic pt_rdy,
  output logic keyed,
  output logic err
);

  localparam int LOAD_W  = KEY_W + IV_W;
  localparam int CNT_MAX = (INIT_ROUNDS > LOAD_W) ? INIT_ROUNDS : LOAD_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rx_state_e          state;
  rx_state_e          state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  // Only LOAD_W-1 bits are stored; the final bit is taken live from cfg_bit.
  logic [LOAD_W-2:0]  stage;
  logic [LOAD_W-1:0]  stage_next;
  logic               stage_shift;
  logic               enter_load;
  logic               limit_trip;
  logic               at_limit;
  logic               accept;
  logic               core_load;
  logic               core_step;
  logic               z;
  logic [STATE_W-1:0] load_val;

  assign stage_next = {cfg_bit, stage};
  assign keyed      = (state == RUN);

  // Initial state image: s1..sKEY_W = key, s94.. = IV, s286..s288 = 1.
  always_comb begin
    load_val                     = '0;
    load_val[KEY_W-1:0]          = stage_next[KEY_W-1:0];
    load_val[IV_BASE +: IV_W]    = stage_next[LOAD_W-1:KEY_W];
    load_val[STATE_W-1 -: 3]     = 3'b111;
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stage_shift = 1'b0;
    enter_load  = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;
    ct_rdy      = 1'b0;
    accept      = 1'b0;
    limit_trip  = 1'b0;
    case (state)
      IDLE: begin
      end
      LOAD: begin
        if (cfg_vld) begin
          stage_shift = 1'b1;
          if (cnt == CNT_W'(LOAD_W - 1)) begin
            core_load  = 1'b1;
            state_next = INIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      INIT: begin
        if (cnt == CNT_W'(INIT_ROUNDS)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          core_step = 1'b1;
          cnt_next  = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        ct_rdy    = (!pt_vld || pt_rdy) && !at_limit;
        accept    = ct_vld && ct_rdy;
        core_step = accept;
        if (ct_vld && at_limit) begin
          state_next = IDLE;
          limit_trip = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A cfg bit outside LOAD starts a new key; it becomes bit 0. Any ct bit
    // accepted on this same cycle belongs to the aborted key and is dropped.
    if (cfg_vld && (state != LOAD)) begin
      state_next  = LOAD;
      cnt_next    = CNT_W'(1);
      stage_shift = 1'b1;
      enter_load  = 1'b1;
      limit_trip  = 1'b0;
    end
  end

  // FSM, load counter and key staging register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      stage <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (stage_shift) begin
        stage <= stage_next[LOAD_W-1:1];
      end
    end
  end

  // One-entry plaintext output register; a new key drops any pending bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pt_vld <= 1'b0;
      pt_bit <= 1'b0;
    end else if (enter_load) begin
      pt_vld <= 1'b0;
    end else if (accept) begin
      pt_vld <= 1'b1;
      pt_bit <= ct_bit ^ z;
    end else if (pt_rdy) begin
      pt_vld <= 1'b0;
    end
  end

  trivium_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (load_val),
    .step     (core_step),
    .z        (z)
  );

`ifdef TRIVIUM_RX_LIMIT_EN
  localparam int BITCNT_W = $clog2(MAX_BITS + 1);

  logic [BITCNT_W-1:0] bitcnt;

  assign at_limit = (bitcnt == BITCNT_W'(MAX_BITS));

  // Per-key accepted-bit counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt <= '0;
      err    <= 1'b0;
    end else begin
      if (enter_load) begin
        bitcnt <= '0;
      end else if (accept) begin
        bitcnt <= bitcnt + BITCNT_W'(1);
      end
      if (limit_trip) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_limit;

  assign at_limit     = 1'b0;
  assign err          = 1'b0;
  assign unused_limit = limit_trip ^ (MAX_BITS == 64'd0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_trivium_rx_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_trivium_rx_decrypt
// Description : Self-checking bench for trivium_rx_decrypt against a
//               bit-array Trivium model (plays the role of the encryptor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trivium_rx_decrypt;

  localparam int INIT_R = 1152;
`ifdef TRIVIUM_RX_LIMIT_EN
  localparam longint unsigned LIM = 16;
  localparam int              CAP = 16;
`else
  localparam longint unsigned LIM = 64'd4294967296;
  localparam int              CAP = 1000000;
`endif

  logic clk     = 1'b0;
  logic rst     = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_vld = 1'b0;
  logic ct_bit  = 1'b0;
  logic ct_vld  = 1'b0;
  logic pt_rdy  = 1'b0;
  logic ct_rdy;
  logic pt_bit;
  logic pt_vld;
  logic keyed;
  logic err;

  int              total = 0;
  int              bad   = 0;
  bit              ms [1:288];
  longint unsigned key_bits = 0;
  bit              exp_err  = 1'b0;

  always #5 clk = ~clk;

  trivium_rx_decrypt #(
    .KEY_W       (80),
    .IV_W        (80),
    .INIT_ROUNDS (INIT_R),
    .MAX_BITS    (LIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_bit (cfg_bit),
    .cfg_vld (cfg_vld),
    .ct_bit  (ct_bit),
    .ct_vld  (ct_vld),
    .ct_rdy  (ct_rdy),
    .pt_bit  (pt_bit),
    .pt_vld  (pt_vld),
    .pt_rdy  (pt_rdy),
    .keyed   (keyed),
    .err     (err)
  );

  function automatic bit [79:0] rand80();
    bit [79:0] v;
    v[31:0]  = $urandom();
    v[63:32] = $urandom();
    v[79:64] = 16'($urandom());
    return v;
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  // Reference keystream step, written directly from the 1-based equations.
  function automatic bit m_step();
    bit t1, t2, t3, zz;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    zz = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t2;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
    ms[1] = t3;
    return zz;
  endfunction

  // Sends key then IV MSB-first (K1 = key[79]); starts and ends at posedge+1.
  task automatic load_key(input string name, input bit [79:0] key, input bit [79:0] iv,
                          input bit gaps, input bit rekey_chk);
    bit [159:0] seq;
    int         edges = 0;
    int         j = 0;
    bit         leak = 1'b0;
    for (int i = 0; i < 80; i++) begin
      seq[i]      = key[79-i];
      seq[80 + i] = iv[79-i];
    end
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = seq[i-1];
      ms[93 + i] = seq[79 + i];
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int r = 0; r < INIT_R; r++) void'(m_step());
    key_bits = 0;
    ct_vld = 1'b1;
    ct_bit = rbit();
    pt_rdy = !rekey_chk;
    while (j < 160) begin
      if (gaps && j > 0 && chance(25)) begin
        cfg_vld = 1'b0;
        cfg_bit = rbit();
      end else begin
        cfg_vld = 1'b1;
        cfg_bit = seq[j];
        j++;
      end
      @(posedge clk); #1;
      edges++;
      if (rekey_chk && edges == 1) begin
        total++;
        if (pt_vld !== 1'b0) begin bad++; $display("FAIL %s_drop: pt_vld=%0b expected=0", name, pt_vld); end
        total++;
        if (keyed !== 1'b0) begin bad++; $display("FAIL %s_keyed: keyed=%0b expected=0", name, keyed); end
        total++;
        if (ct_rdy !== 1'b0) begin bad++; $display("FAIL %s_rdy: ct_rdy=%0b expected=0", name, ct_rdy); end
      end
      if (pt_vld !== 1'b0 || keyed !== 1'b0 || ct_rdy !== 1'b0) leak = 1'b1;
    end
    cfg_vld = 1'b0;
    while (keyed !== 1'b1 && edges < 4 * (160 + INIT_R)) begin
      if (pt_vld !== 1'b0 || ct_rdy !== 1'b0) leak = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    ct_vld = 1'b0;
    total++;
    if (keyed !== 1'b1) begin bad++; $display("FAIL %s_timeout: keyed=%0b expected=1", name, keyed); end
    if (!gaps) begin
      total++;
      if (edges != 160 + INIT_R + 1)
        begin bad++; $display("FAIL %s_latency: cycles=%0d expected=%0d", name, edges, 160 + INIT_R + 1); end
    end
    total++;
    if (leak) begin bad++; $display("FAIL %s_quiet: output activity before RUN=1 expected=0", name); end
  endtask

  // Streams n bits; plaintext random (or = keystream when zero_ct), ct = pt ^ z.
  task automatic run_stream(input string name, input int n_req, input int rdy_pct,
                            input int vld_pct, input bit zero_ct);
    int n;
    bit pt_q[$];
    bit ct_q[$];
    int tx = 0, rx = 0, cyc = 0;
    bit exp_vld = 1'b0;
    bit exp_rdy;
    bit acc;
    bit zz, p;
    n = (n_req > CAP) ? CAP : n_req;
    for (int i = 0; i < n; i++) begin
      zz = m_step();
      p  = zero_ct ? zz : rbit();
      pt_q.push_back(p);
      ct_q.push_back(p ^ zz);
    end
    while (rx < n && cyc < n * 60 + 200) begin
      ct_vld = (tx < n) && chance(vld_pct);
      ct_bit = (tx < n) ? ct_q[tx] : rbit();
      pt_rdy = chance(rdy_pct);
      #1;
      exp_rdy = (!exp_vld || pt_rdy) && (key_bits < LIM);
      total++;
      if (pt_vld !== exp_vld) begin bad++; $display("FAIL %s_vld: pt_vld=%0b expected=%0b", name, pt_vld, exp_vld); end
      total++;
      if (ct_rdy !== exp_rdy) begin bad++; $display("FAIL %s_rdy: ct_rdy=%0b expected=%0b", name, ct_rdy, exp_rdy); end
      if (pt_vld === 1'b1 && pt_rdy) begin
        total++;
        if (pt_bit !== pt_q[rx])
          begin bad++; $display("FAIL %s_bit%0d: pt_bit=%0b expected=%0b", name, rx, pt_bit, pt_q[rx]); end
        rx++;
      end
      acc = ct_vld && (ct_rdy === 1'b1);
      if (acc) begin tx++; key_bits++; end
      exp_vld = acc ? 1'b1 : (pt_rdy ? 1'b0 : exp_vld);
      @(posedge clk); #1;
      cyc++;
    end
    ct_vld = 1'b0;
    total++;
    if (rx != n) begin bad++; $display("FAIL %s_count: received=%0d expected=%0d", name, rx, n); end
    total++;
    if (err !== exp_err) begin bad++; $display("FAIL %s_err: err=%0b expected=%0b", name, err, exp_err); end
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ct_rdy !== 1'b0) begin bad++; $display("FAIL rst_ct_rdy: got=%0b expected=0", ct_rdy); end
    total++;
    if (pt_vld !== 1'b0) begin bad++; $display("FAIL rst_pt_vld: got=%0b expected=0", pt_vld); end
    total++;
    if (pt_bit !== 1'b0) begin bad++; $display("FAIL rst_pt_bit: got=%0b expected=0", pt_bit); end
    total++;
    if (keyed !== 1'b0) begin bad++; $display("FAIL rst_keyed: got=%0b expected=0", keyed); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got=%0b expected=0", err); end
    rst    = 1'b1;
    ct_vld = 1'b1;
    ct_bit = 1'b1;
    pt_rdy = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (ct_rdy !== 1'b0 || pt_vld !== 1'b0 || keyed !== 1'b0 || err !== 1'b0) seen = 1'b1;
    end
    ct_vld = 1'b0;
    total++;
    if (seen) begin bad++; $display("FAIL idle_ct: output activity=1 expected=0"); end
  endtask

  task automatic test_zero_key();
    load_key("zero_key", 80'h0, 80'h0, 1'b0, 1'b0);
    run_stream("zero_ks", 64, 100, 100, 1'b1);
  endtask

  task automatic test_round_trip();
    load_key("rt_key", 80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 1'b1, 1'b0);
    run_stream("round_trip", 1000, 100, 80, 1'b0);
  endtask

  task automatic test_backpressure();
    load_key("bp_key", rand80(), rand80(), 1'b0, 1'b0);
    run_stream("backpressure", 300, 30, 70, 1'b0);
  endtask

  task automatic test_rekey();
    ct_vld = 1'b1;
    ct_bit = rbit();
    pt_rdy = 1'b0;
    @(posedge clk); #1;
    ct_vld = 1'b0;
    total++;
    if (pt_vld !== 1'b1) begin bad++; $display("FAIL rekey_pending: pt_vld=%0b expected=1", pt_vld); end
    load_key("rekey", rand80(), rand80(), 1'b0, 1'b1);
    run_stream("rekey_stream", 100, 60, 90, 1'b0);
  endtask

  task automatic test_async_reset();
    ct_vld = 1'b1;
    ct_bit = rbit();
    pt_rdy = 1'b0;
    @(posedge clk); #1;
    ct_vld = 1'b0;
    total++;
    if (pt_vld !== 1'b1) begin bad++; $display("FAIL arst_pending: pt_vld=%0b expected=1", pt_vld); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (pt_vld !== 1'b0) begin bad++; $display("FAIL arst_pt_vld: got=%0b expected=0", pt_vld); end
    total++;
    if (keyed !== 1'b0) begin bad++; $display("FAIL arst_keyed: got=%0b expected=0", keyed); end
    total++;
    if (pt_bit !== 1'b0) begin bad++; $display("FAIL arst_pt_bit: got=%0b expected=0", pt_bit); end
    @(posedge clk); #1;
    rst     = 1'b1;
    exp_err = 1'b0;
    load_key("arst_key", rand80(), rand80(), 1'b0, 1'b0);
    run_stream("arst_stream", 32, 100, 100, 1'b0);
  endtask

`ifdef TRIVIUM_RX_LIMIT_EN
  task automatic test_limit();
    bit refused = 1'b1;
    load_key("lim_key", rand80(), rand80(), 1'b0, 1'b0);
    run_stream("lim", 16, 100, 100, 1'b0);
    ct_vld = 1'b1;
    ct_bit = 1'b0;
    pt_rdy = 1'b1;
    #1;
    total++;
    if (ct_rdy !== 1'b0) begin bad++; $display("FAIL lim_17th: ct_rdy=%0b expected=0", ct_rdy); end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL lim_err: err=%0b expected=1", err); end
    total++;
    if (keyed !== 1'b0) begin bad++; $display("FAIL lim_keyed: keyed=%0b expected=0", keyed); end
    repeat (4) begin
      @(posedge clk); #1;
      if (ct_rdy !== 1'b0 || pt_vld !== 1'b0) refused = 1'b0;
    end
    ct_vld = 1'b0;
    total++;
    if (!refused) begin bad++; $display("FAIL lim_idle: accepting after limit=1 expected=0"); end
    exp_err = 1'b1;
    load_key("lim_rekey", rand80(), rand80(), 1'b0, 1'b0);
    run_stream("lim_after", 8, 100, 100, 1'b0);
  endtask
`else
  task automatic test_limit();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL nolimit_err: err=%0b expected=0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_round_trip();
    test_backpressure();
    test_rekey();
    test_async_reset();
    test_limit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
